// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage and the flags register:
// opcode encodings and the execution FSM state encoding.
package alu_pkg;

   // Opcode encodings, shared with the downstream flags register
   localparam logic [2:0] SUM   = 3'b000;
   localparam logic [2:0] RES   = 3'b001;
   localparam logic [2:0] PRO   = 3'b010;
   localparam logic [2:0] ANDS  = 3'b011;
   localparam logic [2:0] ORS   = 3'b100;
   localparam logic [2:0] NANDS = 3'b101;
   localparam logic [2:0] NORS  = 3'b110;
   localparam logic [2:0] XORS  = 3'b111;

   // Execution FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // True for opcodes that finish at the accept edge
   function automatic logic is_single_cycle(input logic [2:0] op);
      return op != PRO;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier. One partial-product step per enabled edge;
// 'prod' is the accumulator including the current step's addend, so on the
// step flagged by 'last' it already holds the complete product.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] prod,
   output logic               last
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   // Accumulator value after the current step's conditional add
   always_comb begin
      prod = acc + (mplier[0] ? mcand : '0);
      last = step && (cnt == CW'(WIDTH - 1));
   end

   // Operand load on accept, then one shift-add iteration per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= '0;
      end else if (step) begin
         acc    <= prod;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule : alu_mul_seq

// File: rtl/alu_exec.sv
// ALU execution stage. Single-cycle ops register their result at the accept
// edge; PRO runs the shift-add multiplier for WIDTH cycles. Every completion
// is announced by a one-cycle done strobe in FIN, with result, flags and
// opcode held until the next completion.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         opcode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [2:0]         op_out,
   output logic               carry_flag_sum,
   output logic               zero_flag
);

   state_t             state;
   logic [2:0]         op_lat;
   logic               ready;
   logic               accept;
   logic               mul_load;
   logic               mul_step;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH:0]     single_out;

   // Single-cycle operation mux; bit WIDTH carries the SUM carry-out and is
   // zero for every other opcode (the RES borrow is deliberately dropped).
   function automatic logic [WIDTH:0] single_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH:0] r;
      r = '0;
      case (op)
         SUM:     r = {1'b0, x} + {1'b0, y};
         RES:     r = {1'b0, x - y};
         ANDS:    r = {1'b0, x & y};
         ORS:     r = {1'b0, x | y};
         NANDS:   r = {1'b0, ~(x & y)};
         NORS:    r = {1'b0, ~(x | y)};
         XORS:    r = {1'b0, x ^ y};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Handshake decode and operation mux
   always_comb begin
      ready      = (state == IDLE) || (state == FIN);
      accept     = ready && start;
      mul_load   = accept && !is_single_cycle(opcode);
      mul_step   = (state == MUL);
      single_out = single_op(opcode, a, b);
   end

   alu_mul_seq #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (mul_load),
      .step  (mul_step),
      .a     (a),
      .b     (b),
      .prod  (mul_prod),
      .last  (mul_last)
   );

   // Control FSM with registered outputs; result fields update only on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         op_lat         <= 3'b000;
         busy           <= 1'b0;
         done           <= 1'b0;
         result         <= '0;
         op_out         <= 3'b000;
         carry_flag_sum <= 1'b0;
         zero_flag      <= 1'b0;
      end else begin
         case (state)
            IDLE, FIN: begin
               if (accept) begin
                  op_lat <= opcode;
                  if (is_single_cycle(opcode)) begin
                     state          <= FIN;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     result         <= {{WIDTH{1'b0}}, single_out[WIDTH-1:0]};
                     op_out         <= opcode;
                     carry_flag_sum <= single_out[WIDTH];
                     zero_flag      <= (single_out[WIDTH-1:0] == '0);
                  end else begin
                     state <= MUL;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            MUL: begin
               if (mul_last) begin
                  state          <= FIN;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  result         <= mul_prod;
                  op_out         <= op_lat;
                  carry_flag_sum <= 1'b0;
                  zero_flag      <= (mul_prod == '0);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed operations push their expected
// completion (fields and done cycle) into a queue; a monitor pops on done.
module tb_alu_exec;
   import alu_pkg::*;

   localparam int W = 8;

   typedef struct {
      logic [2*W-1:0] res;
      logic [2:0]     op;
      logic           c;
      logic           z;
      int             cyc;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [2:0]     opcode;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] result;
   logic [2:0]     op_out;
   logic           carry_flag_sum;
   logic           zero_flag;

   exp_t sb[$];
   int   cyc      = 0;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   busy_run = 0;

   alu_exec #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .opcode         (opcode),
      .a              (a),
      .b              (b),
      .busy           (busy),
      .done           (done),
      .result         (result),
      .op_out         (op_out),
      .carry_flag_sum (carry_flag_sum),
      .zero_flag      (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive one operation for one cycle; lat < 0 means no completion is expected
   task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] res, input logic c, input logic z, input int lat);
      exp_t e;
      start  = 1'b1;
      opcode = op;
      a      = x;
      b      = y;
      if (lat > 0) begin
         e.res = res; e.op = op; e.c = c; e.z = z; e.cyc = cyc + lat;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Monitor: compare every completion against the head of the scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            chk("busy_with_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", {16'd0, result}, {16'd0, e.res});
               chk("op_out", {29'd0, op_out}, {29'd0, e.op});
               chk("carry", {31'd0, carry_flag_sum}, {31'd0, e.c});
               chk("zero", {31'd0, zero_flag}, {31'd0, e.z});
               chk("done_cycle", e.cyc, cyc);
               if (e.op == PRO) chk("busy_cycles", busy_run, W);
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got 0, expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; opcode = SUM; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_op_out", {29'd0, op_out}, 32'd0);
      chk("rst_carry", {31'd0, carry_flag_sum}, 32'd0);
      chk("rst_zero", {31'd0, zero_flag}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // SUM with carry out and zero low byte
      issue(SUM, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1);
      @(negedge clk);

      // Products
      issue(PRO, 8'd15, 8'd17, 16'h00FF, 1'b0, 1'b0, 9);
      repeat (9) @(negedge clk);
      issue(PRO, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9);
      repeat (9) @(negedge clk);

      // Zero multiplier, with an ignored SUM pulse during MUL
      issue(PRO, 8'h5A, 8'h00, 16'h0000, 1'b0, 1'b1, 9);
      repeat (2) @(negedge clk);
      issue(SUM, 8'h01, 8'h01, 16'h0000, 1'b0, 1'b0, -1);
      repeat (7) @(negedge clk);

      // Back-to-back single-cycle ops, then a PRO accepted from FIN
      issue(NANDS, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b1, 1);
      issue(RES,   8'h05, 8'h07, 16'h00FE, 1'b0, 1'b0, 1);
      issue(XORS,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1);
      issue(ANDS,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1);
      issue(ORS,   8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1);
      issue(NORS,  8'h0F, 8'hF0, 16'h0000, 1'b0, 1'b1, 1);
      issue(SUM,   8'h80, 8'h7F, 16'h00FF, 1'b0, 1'b0, 1);
      issue(PRO,   8'h03, 8'h04, 16'h000C, 1'b0, 1'b0, 9);
      repeat (10) @(negedge clk);

      // Asynchronous reset in the middle of a PRO
      issue(PRO, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, -1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_op_out", {29'd0, op_out}, 32'd0);
      chk("abort_carry", {31'd0, carry_flag_sum}, 32'd0);
      chk("abort_zero", {31'd0, zero_flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(SUM, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_alu_exec
